// File: rtl/hazard_scoreboard.sv
// Decode-stage register scoreboard: tracks in-flight long-latency results per
// architectural register and stalls decode on RAW/WAW hazards or a full budget.
module hazard_scoreboard #(
    parameter int REG_ADDR_W      = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter bit WB_BYPASS       = 1'b1,
    localparam int NREG  = 1 << REG_ADDR_W,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_rd_we,
    input  logic                  id_long,
    input  logic                  flush,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  hold_flag,
    output logic [NREG-1:0]       busy_vec,
    output logic [CNT_W-1:0]      outstanding,
    output logic                  full,
    output logic                  err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [NREG-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             err_q, err_d;

    logic id_act, track, wb_nz, wb_clear, wb_stray, issue;
    logic clr_rs1, clr_rs2, clr_rd;
    logic raw1, raw2, waw, cap;

    assign id_act   = id_valid & ~flush;
    assign track    = id_rd_we & (id_rd != '0);
    assign wb_nz    = wb_valid & (wb_rd != '0);
    assign wb_clear = wb_nz & busy_q[wb_rd];
    assign wb_stray = wb_nz & ~busy_q[wb_rd];
    assign full     = (outstanding_q == MAX_CNT);

    // Same-cycle completion forwards the result, so the hazard on that register dissolves.
    assign clr_rs1 = WB_BYPASS & wb_valid & (wb_rd == id_rs1) & busy_q[id_rs1];
    assign clr_rs2 = WB_BYPASS & wb_valid & (wb_rd == id_rs2) & busy_q[id_rs2];
    assign clr_rd  = WB_BYPASS & wb_valid & (wb_rd == id_rd)  & busy_q[id_rd];

    assign raw1 = id_act & id_rs1_used & busy_q[id_rs1] & ~clr_rs1;
    assign raw2 = id_act & id_rs2_used & busy_q[id_rs2] & ~clr_rs2;
    assign waw  = id_act & id_rd_we & busy_q[id_rd] & ~clr_rd;
    assign cap  = id_act & id_long & track & full & ~wb_clear;

    assign hold_flag = raw1 | raw2 | waw | cap;
    assign issue     = id_act & ~hold_flag & id_long & track;

    always_comb begin
        busy_d        = busy_q;
        outstanding_d = outstanding_q;
        err_d         = err_q | wb_stray;
        if (wb_clear) busy_d[wb_rd] = 1'b0;
        // Set after clear so a same-register issue keeps the bit.
        if (issue)    busy_d[id_rd] = 1'b1;
        busy_d[0] = 1'b0;
        case ({issue, wb_clear})
            2'b10:   outstanding_d = outstanding_q + ONE;
            2'b01:   outstanding_d = outstanding_q - ONE;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q        <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign busy_vec    = busy_q;
    assign outstanding = outstanding_q;
    assign err         = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: two scoreboards (bypass on/off) driven by identical stimulus.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_long, flush, wb_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;

    logic        hold_b, full_b, err_b;
    logic [31:0] busy_b;
    logic [2:0]  outs_b;
    logic        hold_n, full_n, err_n;
    logic [31:0] busy_n;
    logic [2:0]  outs_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_ADDR_W(5), .MAX_OUTSTANDING(4), .WB_BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_rd_we(id_rd_we), .id_long(id_long), .flush(flush), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .hold_flag(hold_b), .busy_vec(busy_b), .outstanding(outs_b),
        .full(full_b), .err(err_b));

    hazard_scoreboard #(.REG_ADDR_W(5), .MAX_OUTSTANDING(4), .WB_BYPASS(1'b0)) u_nob (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_rd_we(id_rd_we), .id_long(id_long), .flush(flush), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .hold_flag(hold_n), .busy_vec(busy_n), .outstanding(outs_n),
        .full(full_n), .err(err_n));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_rd_we = 0; id_long = 0; flush = 0; wb_valid = 0; wb_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input logic [4:0] rd);
        idle();
        id_valid = 1; id_long = 1; id_rd_we = 1; id_rd = rd;
    endtask

    task automatic set_use(input logic [4:0] rs);
        idle();
        id_valid = 1; id_rs1 = rs; id_rs1_used = 1;
    endtask

    task automatic set_wb(input logic [4:0] rd);
        idle();
        wb_valid = 1; wb_rd = rd;
    endtask

    initial begin
        idle();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        #1;
        chk("rst_busy", busy_b, 32'h0);
        chk("rst_outs", {29'b0, outs_b}, 32'd0);
        chk("rst_full", {31'b0, full_b}, 32'd0);
        chk("rst_err", {31'b0, err_b}, 32'd0);
        chk("rst_hold", {31'b0, hold_b}, 32'd0);

        // load-use: load x5, consumer from next cycle, completion two cycles later
        set_load(5); #1;
        chk("lu_c1_hold", {31'b0, hold_b}, 32'd0);
        tick();
        set_use(5); #1;
        chk("lu_busy5", busy_b, 32'h20);
        chk("lu_c2_hold_b", {31'b0, hold_b}, 32'd1);
        chk("lu_c2_hold_n", {31'b0, hold_n}, 32'd1);
        tick(); #1;
        chk("lu_c3_hold_b", {31'b0, hold_b}, 32'd1);
        chk("lu_c3_hold_n", {31'b0, hold_n}, 32'd1);
        tick();
        set_use(5); wb_valid = 1; wb_rd = 5; #1;
        chk("lu_c4_hold_b", {31'b0, hold_b}, 32'd0);
        chk("lu_c4_hold_n", {31'b0, hold_n}, 32'd1);
        tick();
        set_use(5); #1;
        chk("lu_c5_hold_b", {31'b0, hold_b}, 32'd0);
        chk("lu_c5_hold_n", {31'b0, hold_n}, 32'd0);
        chk("lu_c5_busy_b", busy_b, 32'h0);
        chk("lu_c5_busy_n", busy_n, 32'h0);
        chk("lu_c5_outs", {29'b0, outs_b}, 32'd0);

        // capacity: fill with x1..x4, 5th op to x6 blocked, then freed by x2 completion
        for (int r = 1; r <= 4; r++) begin
            set_load(5'(r)); #1;
            chk($sformatf("cap_iss%0d_hold", r), {31'b0, hold_b}, 32'd0);
            tick();
        end
        chk("cap_outs", {29'b0, outs_b}, 32'd4);
        chk("cap_full", {31'b0, full_b}, 32'd1);
        set_load(6); #1;
        chk("cap_hold_b", {31'b0, hold_b}, 32'd1);
        chk("cap_hold_n", {31'b0, hold_n}, 32'd1);
        tick();
        chk("cap_blocked_busy", busy_b, 32'h1E);
        set_load(6); wb_valid = 1; wb_rd = 2; #1;
        chk("cap_free_hold_b", {31'b0, hold_b}, 32'd0);
        chk("cap_free_hold_n", {31'b0, hold_n}, 32'd0);
        tick();
        idle(); #1;
        chk("cap_swap_outs", {29'b0, outs_n}, 32'd4);
        chk("cap_swap_busy_b", busy_b, 32'h5A);
        chk("cap_swap_busy_n", busy_n, 32'h5A);
        set_wb(1); tick();
        set_wb(3); tick();
        set_wb(4); tick();
        set_wb(6); tick();
        idle(); #1;
        chk("drain_outs", {29'b0, outs_b}, 32'd0);
        chk("drain_busy", busy_b, 32'h0);
        chk("drain_err", {31'b0, err_b}, 32'd0);

        // WAW on x7
        set_load(7); tick();
        idle(); id_valid = 1; id_rd = 7; id_rd_we = 1; #1;
        chk("waw_hold_b", {31'b0, hold_b}, 32'd1);
        chk("waw_hold_n", {31'b0, hold_n}, 32'd1);
        tick();
        wb_valid = 1; wb_rd = 7; #1;
        chk("waw_wb_hold_b", {31'b0, hold_b}, 32'd0);
        chk("waw_wb_hold_n", {31'b0, hold_n}, 32'd1);
        tick();
        wb_valid = 0; #1;
        chk("waw_done_hold_n", {31'b0, hold_n}, 32'd0);
        chk("waw_done_busy", busy_n, 32'h0);

        // load to x0 is never tracked
        set_load(0); #1;
        chk("x0_hold", {31'b0, hold_b}, 32'd0);
        tick();
        chk("x0_outs", {29'b0, outs_b}, 32'd0);
        chk("x0_busy", busy_b, 32'h0);

        // stray completion to x9 sets sticky err
        set_wb(9); tick();
        idle(); #1;
        chk("err_set", {31'b0, err_b}, 32'd1);
        chk("err_outs", {29'b0, outs_b}, 32'd0);
        tick();
        chk("err_sticky", {31'b0, err_n}, 32'd1);

        // flush masks a RAW hazard and blocks issue
        set_load(10); tick();
        set_load(11); id_rs1 = 10; id_rs1_used = 1; flush = 1; #1;
        chk("flush_hold_b", {31'b0, hold_b}, 32'd0);
        chk("flush_hold_n", {31'b0, hold_n}, 32'd0);
        tick();
        chk("flush_busy", busy_b, 32'h400);
        chk("flush_outs", {29'b0, outs_b}, 32'd1);

        // reset mid-flight discards entries, even with an issue offered the same edge
        set_load(12); tick();
        set_load(13); tick();
        chk("pre_rst_outs", {29'b0, outs_b}, 32'd3);
        set_load(14); rst_n = 0; tick();
        rst_n = 1; idle(); #1;
        chk("mid_rst_busy", busy_b, 32'h0);
        chk("mid_rst_outs", {29'b0, outs_b}, 32'd0);
        chk("mid_rst_err", {31'b0, err_b}, 32'd0);
        chk("mid_rst_full", {31'b0, full_n}, 32'd0);
        set_wb(10); tick();
        idle(); #1;
        chk("late_wb_err", {31'b0, err_b}, 32'd1);
        chk("late_wb_outs", {29'b0, outs_b}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised register scoreboard for the decode stage of the five-stage RISC-V pipeline. It generalises single-cycle load-use detection to any number of outstanding long-latency operations (loads with variable memory latency, multi-cycle mul/div). It keeps a busy bit per architectural register and raises `hold_flag` on RAW or WAW hazards against in-flight results, or when the outstanding-operation budget is exhausted. Write-back completions clear busy bits, with an optional same-cycle bypass.

## Interface
Parameters:
- `REG_ADDR_W`, 5, register address width; the scoreboard tracks 2^REG_ADDR_W registers.
- `MAX_OUTSTANDING`, 4, maximum tracked in-flight long-latency ops (must be 1..2^REG_ADDR_W-1).
- `WB_BYPASS`, 1, when 1 a completion in the same cycle resolves the RAW/WAW hazard on that register.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `id_valid`  in  1  decode stage holds a valid instruction.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W  source register addresses.
- `id_rs1_used`, `id_rs2_used`  in  1  source is actually read.
- `id_rd`  in  REG_ADDR_W  destination register.
- `id_rd_we`  in  1  instruction writes `id_rd`.
- `id_long`  in  1  instruction is long-latency (load, mul, div).
- `flush`  in  1  decode instruction is being squashed this cycle.
- `wb_valid`  in  1  a long-latency op completes this cycle.
- `wb_rd`  in  REG_ADDR_W  destination of the completing op.
- `hold_flag`  out  1  stall decode/fetch this cycle (combinational).
- `busy_vec`  out  2^REG_ADDR_W  registered busy bits; bit 0 is always 0.
- `outstanding`  out  $clog2(MAX_OUTSTANDING+1)  registered count of tracked ops.
- `full`  out  1  `outstanding == MAX_OUTSTANDING`.
- `err`  out  1  sticky: completion received for a non-busy register.

## Operation
- Decode hazard terms, each gated by `id_valid & ~flush`:
  - RAW1 = `id_rs1_used & busy[id_rs1] & ~clr(id_rs1)`; RAW2 is the same for rs2.
  - WAW = `id_rd_we & busy[id_rd] & ~clr(id_rd)`.
  - CAP = `id_long & track & full & ~wb_clear`, where `track = id_rd_we & (id_rd != 0)`.
- `clr(r)` = `WB_BYPASS & wb_valid & (wb_rd == r) & busy[r]`. With `WB_BYPASS=0`, `clr` is 0.
- `wb_clear` = `wb_valid & (wb_rd != 0) & busy[wb_rd]`.
- `hold_flag` = RAW1 | RAW2 | WAW | CAP.
- Register x0 is never busy and never tracked. Completions with `wb_rd == 0` are ignored.
- Issue = `id_valid & ~flush & ~hold_flag & id_long & track`.
  - Issue sets `busy[id_rd]` and increments `outstanding`.
  - Non-long instructions never touch state.
- Completion (`wb_clear`) clears `busy[wb_rd]` and decrements `outstanding`.
- Issue and completion in the same cycle:
  - `outstanding` is unchanged (net 0).
  - If they target the same register, the set wins and the bit stays 1.
- Completion for a non-busy, nonzero register: no state change; `err` is set and held until reset.
- `outstanding` never under- or overflows. CAP guarantees no issue at full unless a completion frees a slot in the same cycle.
- `flush` only suppresses hazard evaluation and issue. Entries already issued are not cancelled; they retire via `wb_valid`.

## Timing
- Reset (`rst_n == 0` at a rising edge): `busy_vec = 0`, `outstanding = 0`, `full = 0`, `err = 0`.
  - Reset takes priority over issue and completion in the same cycle.
  - Reset mid-operation discards all tracked entries; completions arriving after reset set `err`.
- Then `hold_flag = 0` follows combinationally, since no register is busy and `full` is 0.
- `hold_flag` is purely combinational from the inputs and current state; zero latency.
- State updates appear one cycle after the issue or completion edge.
- A load issued in cycle N makes `busy_vec[rd] = 1` from cycle N+1.
- A dependent instruction in decode at N+1 holds until the cycle its `wb_valid` arrives (with bypass) or the cycle after (without).
- A classic one-cycle load-use therefore produces exactly one hold cycle when the load completes at N+1 and `WB_BYPASS=0`, and zero hold cycles with bypass.

## Test plan
- Reset, then load x5 (`id_long`, rd=5) in cycle 1; `id_rs1=5` from cycle 2; `wb_valid`/`wb_rd=5` in cycle 4 → `hold_flag` high in cycles 2–3, low in cycle 4 (`WB_BYPASS=1`); `busy_vec[5]` is 0 from cycle 5.
- Same sequence with `WB_BYPASS=0` → `hold_flag` high in cycles 2–4, low in cycle 5.
- Issue 4 loads to x1..x4 back-to-back, then a 5th long op to x6 → `full=1`, `outstanding=4`, `hold_flag=1`. Complete x2 in the same cycle as the 5th op → no hold, `outstanding` stays 4, `busy_vec` = {x1,x3,x4,x6}.
- WAW: load x7 pending, ALU op writing x7 → hold until x7 completes. Load to x0 → no tracking, `outstanding` unchanged, never holds.
- `wb_valid` with `wb_rd=9` while x9 is not busy → `err=1` next cycle and stays 1; `outstanding` unchanged. Assert `flush` with a RAW hazard present → `hold_flag=0` and no issue.
- Assert reset with 3 entries outstanding → next cycle `busy_vec=0`, `outstanding=0`, `err=0`.
